draw_scheduler: RTL

//  Shares the single vga_adapter pixel port (x, y, colour, plot) between several

---
 rtl/draw_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// Purpose : round-robin shares one vga_adapter pixel port between NUM_REQ rectangle-fill requesters.
// Latency : first pixel on the grant cycle, one pixel per clock, done one cycle after the last pixel.
// Backpressure: a requester holds req until its grant; others wait; a w*h draw costs w*h+1 cycles.
//
// Ports:
//   clock, resetn                 clock and async active-low reset
//   req[NUM_REQ]                  level draw requests
//   req_x/req_y/req_w/req_h       per-requester rectangle, packed at [i*W +: W]
//   req_colour                    per-requester fill colour
//   grant, done                   one-cycle one-hot pulses (accepted / finished)
//   busy                          high from grant cycle through last pixel cycle
//   vga_x, vga_y, vga_colour      registered pixel address and colour
//   vga_plot                      registered pixel write enable (low for clipped pixels)
module draw_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COL_W   = 3,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*X_W-1:0]   req_w,
  input  logic [NUM_REQ*Y_W-1:0]   req_h,
  input  logic [NUM_REQ*COL_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCR_H);

  typedef enum logic {S_IDLE, S_DRAW} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [X_W-1:0]     x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [Y_W-1:0]     y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic [COL_W-1:0]   fill_q, fill_d;
  logic               empty_q, empty_d;

  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               busy_q, busy_d, plot_q, plot_d;
  logic [X_W-1:0]     vx_q, vx_d;
  logic [Y_W-1:0]     vy_q, vy_d;
  logic [COL_W-1:0]   vc_q, vc_d;

  // Round-robin pick: first asserted request at or above the pointer, wrapping.
  logic          found;
  logic [IW-1:0] win;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  // Raster position of the pixel currently on the output.
  logic col_last, row_last;
  assign col_last = ({1'b0, col_q} + (X_W+1)'(1)) == {1'b0, w_q};
  assign row_last = ({1'b0, row_q} + (Y_W+1)'(1)) == {1'b0, h_q};

  logic         emit;
  logic [X_W:0] px;
  logic [Y_W:0] py;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    fill_d  = fill_q;
    empty_d = empty_q;
    col_d   = col_q;
    row_d   = row_q;
    grant_d = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    plot_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    emit    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d        = S_DRAW;
          win_d          = win;
          x0_d           = req_x[int'(win)*X_W +: X_W];
          y0_d           = req_y[int'(win)*Y_W +: Y_W];
          w_d            = req_w[int'(win)*X_W +: X_W];
          h_d            = req_h[int'(win)*Y_W +: Y_W];
          fill_d         = req_colour[int'(win)*COL_W +: COL_W];
          empty_d        = (req_w[int'(win)*X_W +: X_W] == '0) ||
                           (req_h[int'(win)*Y_W +: Y_W] == '0);
          col_d          = '0;
          row_d          = '0;
          grant_d[win]   = 1'b1;
          busy_d         = 1'b1;
          rr_d           = (win == IW'(NUM_REQ-1)) ? '0 : win + IW'(1);
          emit           = 1'b1;
        end
      end
      S_DRAW: begin
        if (empty_q || (col_last && row_last)) begin
          state_d       = S_IDLE;
          done_d[win_q] = 1'b1;
        end else begin
          busy_d = 1'b1;
          emit   = 1'b1;
          if (col_last) begin
            col_d = '0;
            row_d = row_q + Y_W'(1);
          end else begin
            col_d = col_q + X_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One extra address bit so off-screen pixels are detected rather than wrapped.
    px = {1'b0, x0_d} + {1'b0, col_d};
    py = {1'b0, y0_d} + {1'b0, row_d};
    if (emit) begin
      vx_d   = px[X_W-1:0];
      vy_d   = py[Y_W-1:0];
      vc_d   = fill_d;
      plot_d = !empty_d && (px < SCR_W_L) && (py < SCR_H_L);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      fill_q  <= '0;
      empty_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      empty_q <= empty_d;
      col_q   <= col_d;
      row_q   <= row_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      plot_q  <= plot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;

endmodule
